// File: rtl/register_file_pkg.sv
// Shared definitions for the general-purpose register file:
// write-port operation encodings and the address-width helper.
package register_file_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  // Width of an index into a bank of n entries; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned n);
    if (n > 1) begin
      return int'($clog2(n));
    end
    return 1;
  endfunction

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: selects a word from the flattened storage,
// forcing zero for out-of-range addresses or a deasserted output enable.
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int unsigned p_data_width = 8,
  parameter int unsigned p_reg_count  = 4,
  localparam int unsigned l_addr_width = addr_width(p_reg_count)
) (
  input  logic [p_reg_count*p_data_width-1:0] i_w_regs,
  input  logic [l_addr_width-1:0]             i_w_raddr,
  input  logic                                i_w_oe,
  output logic [p_data_width-1:0]             o_w_out
);

  logic [p_data_width-1:0] sel_word;

  // Comparing against every legal index doubles as the range check.
  always_comb begin
    sel_word = '0;
    for (int unsigned i = 0; i < p_reg_count; i++) begin
      if (i_w_raddr == l_addr_width'(i)) begin
        sel_word = i_w_regs[i*p_data_width +: p_data_width];
      end
    end
  end

  assign o_w_out = i_w_oe ? sel_word : '0;

endmodule

// File: rtl/register_file.sv
// General-purpose register bank: one load/inc/dec/clear write port, two gated
// combinational read ports, a registered wrap flag and an optional debug view.
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned p_data_width = 8,
  parameter int unsigned p_reg_count  = 4,
  localparam int unsigned l_addr_width = addr_width(p_reg_count)
) (
  input  logic                    i_w_clk,
  input  logic                    i_w_reset,
  input  logic                    i_w_we,
  input  logic [l_addr_width-1:0] i_w_waddr,
  input  logic [1:0]              i_w_op,
  input  logic [p_data_width-1:0] i_w_in,
  input  logic [l_addr_width-1:0] i_w_raddr_a,
  input  logic                    i_w_oe_a,
  output logic [p_data_width-1:0] o_w_out_a,
  input  logic [l_addr_width-1:0] i_w_raddr_b,
  input  logic                    i_w_oe_b,
  output logic [p_data_width-1:0] o_w_out_b,
  output logic                    o_w_wrap
`ifdef DEBUG
  ,
  output logic [p_reg_count*p_data_width-1:0] o_w_disp_out
`endif
);

  typedef logic [p_data_width-1:0] word_t;

  word_t                               regs_q [p_reg_count];
  logic [p_reg_count*p_data_width-1:0] regs_flat;
  logic                                wr_hit;
  logic                                wr_exec;
  word_t                               cur_val;
  word_t                               nxt_val;
  logic                                wrap_d;
  logic                                wrap_q;

  // Write-address decode; an address with no matching register is ignored.
  always_comb begin
    wr_hit  = 1'b0;
    cur_val = '0;
    for (int unsigned i = 0; i < p_reg_count; i++) begin
      if (i_w_waddr == l_addr_width'(i)) begin
        wr_hit  = 1'b1;
        cur_val = regs_q[i];
      end
    end
  end

  assign wr_exec = i_w_we & wr_hit;

  always_comb begin
    nxt_val = '0;
    wrap_d  = 1'b0;
    unique case (op_e'(i_w_op))
      OP_LOAD: nxt_val = i_w_in;
      OP_INC: begin
        nxt_val = cur_val + word_t'(1);
        wrap_d  = &cur_val;
      end
      OP_DEC: begin
        nxt_val = cur_val - word_t'(1);
        wrap_d  = ~|cur_val;
      end
      OP_CLR:  nxt_val = '0;
      default: nxt_val = '0;
    endcase
  end

  // Reset wins over a same-cycle write; the wrap flag only moves on executed ops.
  always_ff @(posedge i_w_clk) begin
    if (i_w_reset) begin
      for (int unsigned i = 0; i < p_reg_count; i++) begin
        regs_q[i] <= '0;
      end
      wrap_q <= 1'b0;
    end else if (wr_exec) begin
      for (int unsigned i = 0; i < p_reg_count; i++) begin
        if (i_w_waddr == l_addr_width'(i)) begin
          regs_q[i] <= nxt_val;
        end
      end
      wrap_q <= wrap_d;
    end
  end

  for (genvar g = 0; g < p_reg_count; g++) begin : g_flat
    assign regs_flat[g*p_data_width +: p_data_width] = regs_q[g];
  end

  register_file_read_port #(
    .p_data_width(p_data_width),
    .p_reg_count (p_reg_count)
  ) u_read_a (
    .i_w_regs (regs_flat),
    .i_w_raddr(i_w_raddr_a),
    .i_w_oe   (i_w_oe_a),
    .o_w_out  (o_w_out_a)
  );

  register_file_read_port #(
    .p_data_width(p_data_width),
    .p_reg_count (p_reg_count)
  ) u_read_b (
    .i_w_regs (regs_flat),
    .i_w_raddr(i_w_raddr_b),
    .i_w_oe   (i_w_oe_b),
    .o_w_out  (o_w_out_b)
  );

  assign o_w_wrap = wrap_q;

`ifdef DEBUG
  assign o_w_disp_out = regs_flat;
`endif

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Parametrised bank of p_reg_count registers, each p_data_width bits wide.
- One write port that can load, increment, decrement or clear the addressed register.
- Two independent read ports, each with its own output enable.
- Successor to the single storage register: used as the general-purpose register set of the datapath, with a debug view of every register and a registered wrap flag.

Parameters:
- p_data_width, 8: bits per register.
- p_reg_count, 4: number of registers, range 2..256, not required to be a power of two.
- Local constant (not overridable): l_addr_width = clog2(p_reg_count), minimum 1.

Ports:
- i_w_clk  input  1  clock; every state change happens on its rising edge.
- i_w_reset  input  1  synchronous, active-high reset.
- i_w_we  input  1  write-port enable.
- i_w_waddr  input  l_addr_width  target register of the write port.
- i_w_op  input  2  write operation: 00 load, 01 increment, 10 decrement, 11 clear.
- i_w_in  input  p_data_width  load data; used only when op = 00.
- i_w_raddr_a  input  l_addr_width  read port A address.
- i_w_oe_a  input  1  read port A output enable.
- o_w_out_a  output  p_data_width  read port A data.
- i_w_raddr_b  input  l_addr_width  read port B address.
- i_w_oe_b  input  1  read port B output enable.
- o_w_out_b  output  p_data_width  read port B data.
- o_w_wrap  output  1  registered flag: the last executed operation wrapped around.
- o_w_disp_out  output  p_reg_count*p_data_width  debug view of all registers; reg0 in the LSBs. Present only when DEBUG is defined.

Behaviour:
- Reset: when i_w_reset = 1 at a rising edge, all registers and o_w_wrap go to 0.
  - Reset overrides a simultaneous write.
  - Reset asserted in the middle of a write sequence discards that cycle's operation.
- Write: when i_w_we = 1 and i_w_waddr < p_reg_count, the addressed register R is updated at the edge:
  - load: R <= i_w_in
  - increment: R <= R+1, modulo 2^p_data_width
  - decrement: R <= R-1, modulo 2^p_data_width
  - clear: R <= 0
- Other registers hold their value.
- i_w_we = 0, or an out-of-range i_w_waddr: no register changes and o_w_wrap holds.
- o_w_wrap: updated on every executed operation (valid address, i_w_we = 1).
  - Set to 1 when an increment goes from all-ones to 0.
  - Set to 1 when a decrement goes from 0 to all-ones.
  - Set to 0 for any other executed operation, including load and clear.
- Reads are combinational, with zero latency, from the current register state.
  - o_w_out_x = register[i_w_raddr_x] when i_w_oe_x = 1.
  - o_w_out_x = 0 when i_w_oe_x = 0 or the address is out of range.
- No write-to-read bypass: reading the register being written in the same cycle returns the old value; the new value appears the cycle after the edge.
- Both read ports may address the same register at the same time; both return identical data.
- o_w_disp_out is always driven from the storage and ignores the output enables.
- All outputs are 0 after reset.

Decomposition:
- Shared package holds:
  - the operation encodings: OP_LOAD = 2'b00, OP_INC = 2'b01, OP_DEC = 2'b10, OP_CLR = 2'b11
  - the clog2-based address-width function
- One natural sub-module, register_file_read_port: address decode, range check, OE gating. Instantiated twice.
- Storage, the write ALU (load/inc/dec/clear) and wrap-flag logic stay in the top module.

Test Plan (p_data_width = 8, p_reg_count = 4 unless noted):
- Reset then read: after reset, read every address with OE = 1. Required: A = B = 0, disp_out = 0, o_w_wrap = 0.
- Load and read in the same cycle: load 0xA5 into reg2 while port A reads reg2. Required: A = 0x00 in that cycle, A = 0xA5 the next cycle, B on reg2 = 0xA5.
- Increment wrap: load 0xFF into reg1, then increment. Required: reg1 = 0x00 and o_w_wrap = 1. A following increment gives reg1 = 0x01 and o_w_wrap = 0.
- Decrement wrap and flag hold: decrement reg0 from 0. Required: reg0 = 0xFF and o_w_wrap = 1. A following cycle with i_w_we = 0 keeps o_w_wrap = 1.
- OE gating and out-of-range (p_reg_count = 3): load 0x3C into reg0, then read address 3 and address 0 with OE = 0. Required: both reads return 0.
  - A write to address 3 with value 0x77 changes nothing in disp_out.
- Synchronous reset over a write: assert i_w_reset together with a load of 0x12 into reg3. Required: reg3 = 0 after the edge.
  - Reset is not asynchronous: asserting it between clock edges leaves the outputs unchanged until the next rising edge.
